// File: rtl/muxed_dff_reg.sv
`default_nettype none
// ============================================================================
// Module   : muxed_dff_reg
// Purpose  : Wide load-enable storage register.
//            Each bit is a 2:1 hold/load mux feeding an async-reset D flop.
// Revision : 1.0 - initial release
// ============================================================================
module muxed_dff_reg #(
    parameter int               WIDTH       = 512,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_en,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic r_bit;

            // Mux: i0 = current Q (hold), i1 = data_in (load), sel = write_en
            assign w_next[i] = write_en ? data_in[i] : w_q[i];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_bit <= RESET_VALUE[i];
                end else begin
                    r_bit <= w_next[i];
                end
            end

            assign w_q[i] = r_bit;
        end
    endgenerate

    assign data_out = w_q;

endmodule
`default_nettype wire

// File: tb/tb_muxed_dff_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxed_dff_reg
// Purpose  : Scoreboard bench for muxed_dff_reg with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muxed_dff_reg;

    localparam int               C_WIDTH = 512;
    localparam logic [C_WIDTH-1:0] C_RST = '0;

    logic               clk;
    logic               reset;
    logic [C_WIDTH-1:0] data_in;
    logic               write_en;
    logic [C_WIDTH-1:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [C_WIDTH-1:0] sb_q[$];
    logic [C_WIDTH-1:0] model_word;
    event               mon_ev;

    muxed_dff_reg #(
        .WIDTH       (C_WIDTH),
        .RESET_VALUE (C_RST)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the stored word is the last value written since reset.
    initial model_word = C_RST;

    always @(negedge reset) model_word = C_RST;

    always @(posedge clk) begin
        if (!reset)
            model_word = C_RST;
        else if (write_en)
            model_word = data_in;
        sb_q.push_back(model_word);
        #1 -> mon_ev;
    end

    always @(mon_ev) begin
        logic [C_WIDTH-1:0] exp_word;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: actual queue size 0, required >=1 at %0t", $time);
        end else begin
            exp_word = sb_q.pop_front();
            if (data_out !== exp_word) begin
                n_fail++;
                $display("FAIL data_out at %0t: actual=%h required=%h", $time, data_out, exp_word);
            end
        end
    end

    function automatic logic [C_WIDTH-1:0] rand_word();
        logic [C_WIDTH-1:0] w;
        for (int k = 0; k < C_WIDTH / 32; k++)
            w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive(input logic we, input logic [C_WIDTH-1:0] d);
        @(negedge clk);
        write_en = we;
        data_in  = d;
    endtask

    // Asserts reset between edges and checks the clear happens with no clock.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb_q.push_back(C_RST);
        -> mon_ev;
    endtask

    initial begin
        reset    = 1'b0;
        write_en = 1'b1;
        data_in  = '1;
        #1;
        sb_q.push_back(C_RST);
        -> mon_ev;

        // Reset held across edges with a load requested: no load
        repeat (2) @(negedge clk);

        reset = 1'b1;
        write_en = 1'b1;
        data_in  = '0;
        drive(1'b0, '0);
        drive(1'b1, {448'b0, 64'h000000000000AA00});
        drive(1'b0, {448'b0, 64'h00000000BB000000});
        drive(1'b0, {448'b0, 64'h00000000BB000000});
        drive(1'b1, {448'b0, 64'h00000000BB000000});
        drive(1'b0, '0);
        drive(1'b0, '0);

        async_reset_check();
        @(negedge clk);
        reset = 1'b1;
        write_en = 1'b0;
        data_in  = rand_word();
        drive(1'b0, rand_word());

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset_check();
                @(negedge clk);
                reset = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), rand_word());
        end

        drive(1'b0, '0);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: actual size %0d, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual time %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
